sram_bus_arb: RTL and testbench
===============================

SRAM_BUS_ARB -- requirements
Module: sram_bus_arb

Interface
REQ-001 Parameters SHALL be none; all widths are fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 inst_req, data_req  in  1  requester holds high, with fields stable, until its addr_ok.
REQ-005 inst_wr, data_wr  in  1  1 = write, 0 = read.
REQ-006 inst_size, data_size  in  2  0 = byte, 1 = half, 2 = word.
REQ-007 inst_wstrb, data_wstrb  in  4  byte strobes.
REQ-008 inst_addr, data_addr  in  32  request address.
REQ-009 inst_wdata, data_wdata  in  32  write data.
REQ-010 inst_addr_ok, data_addr_ok  out  1  request accepted this cycle.
REQ-011 inst_data_ok, data_data_ok  out  1  response valid this cycle.
REQ-012 inst_rdata, data_rdata  out  32  response data.
REQ-013 inst_cancel  in  1  pipeline flush: discard any in-flight inst response.
REQ-014 m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata  out  1/1/2/4/32/32  shared memory-port request.
REQ-015 m_addr_ok, m_data_ok  in  1  memory handshakes.
REQ-016 m_rdata  in  32  memory read data.

Function
REQ-017 The block SHALL run an FSM with states IDLE, ADDR and RESP, and allow at most one outstanding transaction.
REQ-018 In IDLE with any request present, the block SHALL grant an owner, record it in the owner register, and enter ADDR on the next edge; m_req SHALL stay 0 in IDLE.
REQ-019 Arbitration: if only one requester is active, it wins; if both are active, the one not served last wins; last_owner SHALL reset to inst, so data wins the first tie.
REQ-020 In ADDR, m_req SHALL be 1, and m_wr, m_size, m_wstrb, m_addr and m_wdata SHALL be muxed combinationally from the owner's inputs.
REQ-021 In ADDR with m_addr_ok=1, the owner's addr_ok SHALL be 1 in the same cycle, last_owner SHALL update, and the FSM SHALL enter RESP.
REQ-022 The non-owner's addr_ok SHALL be 0 in every state; a non-owner request SHALL wait without being dropped.
REQ-023 In RESP with m_data_ok=1, the owner's data_ok SHALL be 1 and its rdata SHALL equal m_rdata in the same cycle (zero added latency), and the FSM SHALL return to IDLE.
REQ-024 A grant SHALL NOT be issued in the same cycle as a return to IDLE, so the minimum turnaround is 1 idle cycle.
REQ-025 For writes, data_ok SHALL still be returned; rdata is don't-care.
REQ-026 inst_cancel=1 while the inst requester owns the port in ADDR or RESP SHALL set a discard flag; the bus transaction SHALL complete normally.
REQ-027 While the discard flag is set, inst_data_ok SHALL be suppressed (0) for that transaction.
REQ-028 The discard flag SHALL clear when the transaction retires.
REQ-029 inst_cancel in IDLE, or while data owns the port, SHALL have no effect.
REQ-030 inst_cancel asserted in the same cycle as m_data_ok for an inst transaction SHALL suppress that inst_data_ok.
REQ-031 m_data_ok in IDLE or ADDR SHALL be ignored.
REQ-032 m_addr_ok outside ADDR SHALL be ignored.
REQ-033 An owner that drops req in ADDR is a protocol violation; behaviour is undefined and the bench SHALL flag it.
REQ-034 rdata outputs SHALL be 0 whenever the corresponding data_ok is 0.

Reset
REQ-035 reset SHALL force, asynchronously: FSM=IDLE, last_owner=inst, discard=0, owner=inst.
REQ-036 During and after reset, all outputs SHALL be 0 until the first grant.
REQ-037 reset mid-transaction SHALL abandon it, and no data_ok SHALL be issued for it afterwards.

Verification
REQ-038 inst read addr 0x1c000000, m_addr_ok after 2 cycles, m_data_ok with 0x02800000 after 3 more -> inst_addr_ok on the m_addr_ok cycle; inst_data_ok=1 and inst_rdata=0x02800000 on the m_data_ok cycle; data_* outputs stay 0.
REQ-039 inst and data req in the same cycle after reset -> data granted first (m_addr = data_addr); inst granted after data retires plus 1 idle cycle.
REQ-040 Both requesters held continuously for 6 transactions -> grants alternate data, inst, data, inst, data, inst.
REQ-041 inst read in RESP, inst_cancel pulsed 1 cycle, m_data_ok 2 cycles later -> inst_data_ok stays 0 and FSM returns to IDLE; the next inst request completes normally.
REQ-042 data write wstrb=0x3, size=1, addr=0x8 -> m_wr=1, m_wstrb=0x3, m_size=1; data_data_ok=1 on m_data_ok.
REQ-043 reset asserted in RESP, then m_data_ok arrives -> no data_ok on either port; all outputs 0.

Source files
------------

// File: rtl/sram_bus_arb_if.sv
// SRAM-style request/response bus shared by both requesters and the memory port.
//   master modport: drives req, wr, size, wstrb, addr, wdata; receives addr_ok, data_ok, rdata
//   slave  modport: receives the request fields; drives addr_ok, data_ok, rdata
// size: 0 = byte, 1 = half, 2 = word. wr: 1 = write, 0 = read.
interface sram_bus_arb_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_bus_arb.sv
// Two-requester arbiter (instruction fetch and data) onto a single SRAM-style memory port.
// At most one transaction is outstanding. Ties alternate, starting with data after reset.
// Ports:
//   clk         - clock, all state on the rising edge
//   reset       - asynchronous, active-high
//   inst_cancel - flush: suppress the response of an in-flight inst transaction
//   inst, data  - requester buses (slave side of sram_bus_arb_if)
//   mem         - shared memory port (master side of sram_bus_arb_if)
module sram_bus_arb (
  input  logic          clk,
  input  logic          reset,
  input  logic          inst_cancel,
  sram_bus_arb_if.slave  inst,
  sram_bus_arb_if.slave  data,
  sram_bus_arb_if.master mem
);

  typedef enum logic [1:0] {StIdle, StAddr, StResp} state_e;
  typedef enum logic {OwnInst = 1'b0, OwnData = 1'b1} owner_e;

  state_e state_q;
  owner_e owner_q;
  owner_e last_owner_q;
  logic   discard_q;

  owner_e grant;
  logic   any_req;
  logic   in_addr;
  logic   in_resp;
  logic   inst_owns;
  logic   cancel_hit;
  logic   retire;

  // On a tie the requester not served last wins.
  always_comb begin
    grant = OwnInst;
    if (data.req && (!inst.req || (last_owner_q == OwnInst))) begin
      grant = OwnData;
    end
  end

  assign any_req    = inst.req | data.req;
  assign in_addr    = (state_q == StAddr);
  assign in_resp    = (state_q == StResp);
  assign inst_owns  = (owner_q == OwnInst);
  assign cancel_hit = inst_cancel & inst_owns & (in_addr | in_resp);
  assign retire     = in_resp & mem.data_ok;

  // Grants are only evaluated in StIdle, so a retiring cycle never grants: one idle
  // cycle always separates transactions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnInst;
      last_owner_q <= OwnInst;
      discard_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_q <= grant;
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (cancel_hit) begin
            discard_q <= 1'b1;
          end
          if (mem.addr_ok) begin
            last_owner_q <= owner_q;
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (mem.data_ok) begin
            discard_q <= 1'b0;
            state_q   <= StIdle;
          end else if (cancel_hit) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory request: owner's fields while in StAddr, all zero otherwise.
  always_comb begin
    mem.req   = 1'b0;
    mem.wr    = 1'b0;
    mem.size  = 2'd0;
    mem.wstrb = 4'd0;
    mem.addr  = 32'd0;
    mem.wdata = 32'd0;
    if (in_addr) begin
      mem.req = 1'b1;
      if (inst_owns) begin
        mem.wr    = inst.wr;
        mem.size  = inst.size;
        mem.wstrb = inst.wstrb;
        mem.addr  = inst.addr;
        mem.wdata = inst.wdata;
      end else begin
        mem.wr    = data.wr;
        mem.size  = data.size;
        mem.wstrb = data.wstrb;
        mem.addr  = data.addr;
        mem.wdata = data.wdata;
      end
    end
  end

  // Handshakes pass straight through to the owner; a same-cycle cancel also
  // suppresses the inst response.
  assign inst.addr_ok = in_addr & inst_owns & mem.addr_ok;
  assign data.addr_ok = in_addr & ~inst_owns & mem.addr_ok;
  assign inst.data_ok = retire & inst_owns & ~discard_q & ~inst_cancel;
  assign data.data_ok = retire & ~inst_owns;
  assign inst.rdata   = inst.data_ok ? mem.rdata : 32'd0;
  assign data.rdata   = data.data_ok ? mem.rdata : 32'd0;

endmodule

// File: tb/tb_sram_bus_arb.sv
// Self-checking bench for sram_bus_arb: directed scenarios plus a randomized run checked
// against a transaction-level model of the shared port.
module tb_sram_bus_arb;

  logic clk = 1'b0;
  logic reset;
  logic inst_cancel;

  sram_bus_arb_if inst_bus ();
  sram_bus_arb_if data_bus ();
  sram_bus_arb_if mem_bus ();

  sram_bus_arb dut (
    .clk         (clk),
    .reset       (reset),
    .inst_cancel (inst_cancel),
    .inst        (inst_bus),
    .data        (data_bus),
    .mem         (mem_bus)
  );

  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
  function automatic logic [4:0] flags();
    return {mem_bus.req, inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok};
  endfunction

  function automatic logic [139:0] all_out();
    return {mem_bus.req, mem_bus.wr, mem_bus.size, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata,
            inst_bus.addr_ok, inst_bus.data_ok, inst_bus.rdata,
            data_bus.addr_ok, data_bus.data_ok, data_bus.rdata};
  endfunction

  task automatic idle_inputs();
    inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd0; inst_bus.wstrb = 4'd0;
    inst_bus.addr = 32'd0; inst_bus.wdata = 32'd0;
    data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd0; data_bus.wstrb = 4'd0;
    data_bus.addr = 32'd0; data_bus.wdata = 32'd0;
    mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = 32'd0;
    inst_cancel = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    inst_bus.req = 1'b1; data_bus.req = 1'b1; inst_cancel = 1'b1;
    mem_bus.addr_ok = 1'b1; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hffff_ffff;
    @(negedge clk);
    n_vec++;
    if (all_out() !== '0) begin
      n_err++; $display("FAIL rst_hold: outputs got %h want 0", all_out());
    end
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (all_out() !== '0) begin
      n_err++; $display("FAIL rst_release: outputs got %h want 0", all_out());
    end
    next_cycle();
    inst_bus.req = 1'b1; inst_bus.addr = 32'h10;
    @(negedge clk);
    n_vec++;
    if (all_out() !== '0) begin
      n_err++; $display("FAIL rst_pre_grant: outputs got %h want 0", all_out());
    end
    next_cycle();
    @(negedge clk);
    n_vec++;
    if (flags() !== 5'b10000) begin
      n_err++; $display("FAIL rst_first_grant: flags got %b want %b", flags(), 5'b10000);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (all_out() !== '0) begin
      n_err++; $display("FAIL rst_async: outputs got %h want 0", all_out());
    end
    next_cycle();
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_inst_read();
    do_reset();
    inst_bus.req = 1'b1; inst_bus.size = 2'd2; inst_bus.wstrb = 4'hf;
    inst_bus.addr = 32'h1c00_0000;
    @(negedge clk);
    n_vec++;
    if (flags() !== 5'b00000) begin
      n_err++; $display("FAIL ir_idle: flags got %b want %b", flags(), 5'b00000);
    end
    next_cycle();
    @(negedge clk);
    n_vec++;
    if ({flags(), mem_bus.addr} !== {5'b10000, 32'h1c00_0000}) begin
      n_err++; $display("FAIL ir_addr_wait: flags/addr got %b/%h want 10000/1c000000",
                        flags(), mem_bus.addr);
    end
    next_cycle();
    mem_bus.addr_ok = 1'b1;
    @(negedge clk);
    n_vec++;
    if (flags() !== 5'b11000) begin
      n_err++; $display("FAIL ir_addr_ok: flags got %b want %b", flags(), 5'b11000);
    end
    next_cycle();
    inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({flags(), inst_bus.rdata} !== 37'd0) begin
      n_err++; $display("FAIL ir_resp_wait: flags/rdata got %b/%h want 0/0",
                        flags(), inst_bus.rdata);
    end
    next_cycle();
    next_cycle();
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0280_0000;
    @(negedge clk);
    n_vec++;
    if ({flags(), inst_bus.rdata, data_bus.rdata} !== {5'b00010, 32'h0280_0000, 32'd0}) begin
      n_err++; $display("FAIL ir_data_ok: flags/irdata/drdata got %b/%h/%h want 00010/02800000/0",
                        flags(), inst_bus.rdata, data_bus.rdata);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (all_out() !== '0) begin
      n_err++; $display("FAIL ir_back_idle: outputs got %h want 0", all_out());
    end
  endtask

  task automatic test_tie();
    do_reset();
    inst_bus.req = 1'b1; inst_bus.addr = 32'h100;
    data_bus.req = 1'b1; data_bus.addr = 32'h200;
    next_cycle();
    mem_bus.addr_ok = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({flags(), mem_bus.addr} !== {5'b10100, 32'h200}) begin
      n_err++; $display("FAIL tie_data_first: flags/addr got %b/%h want 10100/200",
                        flags(), mem_bus.addr);
    end
    next_cycle();
    data_bus.req = 1'b0; mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
    mem_bus.rdata = 32'h0000_aaaa;
    @(negedge clk);
    n_vec++;
    if ({flags(), data_bus.rdata} !== {5'b00001, 32'h0000_aaaa}) begin
      n_err++; $display("FAIL tie_data_resp: flags/rdata got %b/%h want 00001/0000aaaa",
                        flags(), data_bus.rdata);
    end
    next_cycle();
    mem_bus.data_ok = 1'b0;
    @(negedge clk);
    n_vec++;
    if (flags() !== 5'b00000) begin
      n_err++; $display("FAIL tie_turnaround: flags got %b want %b", flags(), 5'b00000);
    end
    next_cycle();
    mem_bus.addr_ok = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({flags(), mem_bus.addr} !== {5'b11000, 32'h100}) begin
      n_err++; $display("FAIL tie_inst_second: flags/addr got %b/%h want 11000/100",
                        flags(), mem_bus.addr);
    end
    next_cycle();
    idle_inputs();
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h5555;
    @(negedge clk);
    n_vec++;
    if ({flags(), inst_bus.rdata} !== {5'b00010, 32'h5555}) begin
      n_err++; $display("FAIL tie_inst_resp: flags/rdata got %b/%h want 00010/5555",
                        flags(), inst_bus.rdata);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_alternate();
    logic [4:0]  exp_a;
    logic [4:0]  exp_d;
    logic [31:0] exp_addr;
    do_reset();
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1000;
    data_bus.req = 1'b1; data_bus.addr = 32'h2000;
    for (int k = 0; k < 6; k++) begin
      exp_a    = (k % 2 == 0) ? 5'b10100 : 5'b11000;
      exp_d    = (k % 2 == 0) ? 5'b00001 : 5'b00010;
      exp_addr = (k % 2 == 0) ? 32'h2000 : 32'h1000;
      @(negedge clk);
      n_vec++;
      if (flags() !== 5'b00000) begin
        n_err++; $display("FAIL alt_idle[%0d]: flags got %b want 00000", k, flags());
      end
      next_cycle();
      mem_bus.addr_ok = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({flags(), mem_bus.addr} !== {exp_a, exp_addr}) begin
        n_err++; $display("FAIL alt_grant[%0d]: flags/addr got %b/%h want %b/%h",
                          k, flags(), mem_bus.addr, exp_a, exp_addr);
      end
      next_cycle();
      mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
      @(negedge clk);
      n_vec++;
      if (flags() !== exp_d) begin
        n_err++; $display("FAIL alt_resp[%0d]: flags got %b want %b", k, flags(), exp_d);
      end
      next_cycle();
      mem_bus.data_ok = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_cancel();
    do_reset();
    inst_bus.req = 1'b1; inst_bus.addr = 32'h40;
    next_cycle();
    mem_bus.addr_ok = 1'b1;
    @(negedge clk);
    n_vec++;
    if (flags() !== 5'b11000) begin
      n_err++; $display("FAIL cx_accept: flags got %b want %b", flags(), 5'b11000);
    end
    next_cycle();
    inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0; inst_cancel = 1'b1;
    next_cycle();
    inst_cancel = 1'b0;
    next_cycle();
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hdead_beef;
    @(negedge clk);
    n_vec++;
    if ({flags(), inst_bus.rdata} !== 37'd0) begin
      n_err++; $display("FAIL cx_suppressed: flags/rdata got %b/%h want 0/0",
                        flags(), inst_bus.rdata);
    end
    next_cycle();
    mem_bus.data_ok = 1'b0;
    inst_bus.req = 1'b1; inst_bus.addr = 32'h44;
    @(negedge clk);
    n_vec++;
    if (flags() !== 5'b00000) begin
      n_err++; $display("FAIL cx_back_idle: flags got %b want %b", flags(), 5'b00000);
    end
    next_cycle();
    mem_bus.addr_ok = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({flags(), mem_bus.addr} !== {5'b11000, 32'h44}) begin
      n_err++; $display("FAIL cx_next_grant: flags/addr got %b/%h want 11000/44",
                        flags(), mem_bus.addr);
    end
    next_cycle();
    inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
    mem_bus.rdata = 32'h1234;
    @(negedge clk);
    n_vec++;
    if ({flags(), inst_bus.rdata} !== {5'b00010, 32'h1234}) begin
      n_err++; $display("FAIL cx_next_resp: flags/rdata got %b/%h want 00010/1234",
                        flags(), inst_bus.rdata);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_data_write();
    do_reset();
    data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.size = 2'd1; data_bus.wstrb = 4'h3;
    data_bus.addr = 32'h8; data_bus.wdata = 32'hcafe_f00d;
    next_cycle();
    mem_bus.addr_ok = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({flags(), mem_bus.wr, mem_bus.size, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata} !==
        {5'b10100, 1'b1, 2'd1, 4'h3, 32'h8, 32'hcafe_f00d}) begin
      n_err++; $display("FAIL wr_fields: flags/wr/size/wstrb/addr/wdata got %b/%b/%0d/%h/%h/%h",
                        flags(), mem_bus.wr, mem_bus.size, mem_bus.wstrb, mem_bus.addr,
                        mem_bus.wdata);
    end
    next_cycle();
    data_bus.req = 1'b0; mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
    @(negedge clk);
    n_vec++;
    if (flags() !== 5'b00001) begin
      n_err++; $display("FAIL wr_data_ok: flags got %b want %b", flags(), 5'b00001);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    inst_bus.req = 1'b1; inst_bus.addr = 32'h80;
    next_cycle();
    mem_bus.addr_ok = 1'b1;
    next_cycle();
    inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (all_out() !== '0) begin
      n_err++; $display("FAIL rm_in_reset: outputs got %h want 0", all_out());
    end
    next_cycle();
    reset = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hffff_ffff;
    @(negedge clk);
    n_vec++;
    if (all_out() !== '0) begin
      n_err++; $display("FAIL rm_late_data_ok: outputs got %h want 0", all_out());
    end
    next_cycle();
    idle_inputs();
  endtask

  // Random traffic on both requesters and a memory with random latencies and stray
  // handshakes. The model tracks the port as one transaction record (owner, address
  // accepted, response to be dropped) and applies the arbitration rules directly.
  task automatic test_random();
    logic        pend    [2];
    logic        f_wr    [2];
    logic [1:0]  f_size  [2];
    logic [3:0]  f_wstrb [2];
    logic [31:0] f_addr  [2];
    logic [31:0] f_wdata [2];
    int          cur;   // -1: port free, 0: inst, 1: data
    int          own;
    int          last;
    int          wait_cnt;
    bit          acc;
    bit          drop;
    bit          exp_mreq;
    bit          retire;
    logic [70:0] exp_fields;
    logic [1:0]  exp_aok;
    logic [1:0]  exp_dok;
    logic [31:0] exp_rd [2];

    do_reset();
    cur = -1; last = 0; wait_cnt = 0; acc = 1'b0; drop = 1'b0;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; f_wr[r] = 1'b0; f_size[r] = 2'd0; f_wstrb[r] = 4'd0;
      f_addr[r] = 32'd0; f_wdata[r] = 32'd0;
    end

    for (int t = 0; t < 2000; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r]    = 1'b1;
          f_wr[r]    = 1'($urandom_range(0, 1));
          f_size[r]  = 2'($urandom_range(0, 2));
          f_wstrb[r] = 4'($urandom);
          f_addr[r]  = $urandom;
          f_wdata[r] = $urandom;
        end
      end
      inst_bus.req = pend[0]; inst_bus.wr = f_wr[0]; inst_bus.size = f_size[0];
      inst_bus.wstrb = f_wstrb[0]; inst_bus.addr = f_addr[0]; inst_bus.wdata = f_wdata[0];
      data_bus.req = pend[1]; data_bus.wr = f_wr[1]; data_bus.size = f_size[1];
      data_bus.wstrb = f_wstrb[1]; data_bus.addr = f_addr[1]; data_bus.wdata = f_wdata[1];
      inst_cancel = ($urandom_range(0, 5) == 0);

      mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = $urandom;
      if (cur >= 0) begin
        if (wait_cnt == 0) begin
          if (!acc) mem_bus.addr_ok = 1'b1;
          else      mem_bus.data_ok = 1'b1;
        end else begin
          wait_cnt--;
        end
      end
      // Stray handshakes where the arbiter must ignore them.
      if ((cur < 0 || acc) && $urandom_range(0, 4) == 0) mem_bus.addr_ok = 1'b1;
      if ((cur < 0 || !acc) && $urandom_range(0, 4) == 0) mem_bus.data_ok = 1'b1;

      @(negedge clk);
      own        = (cur < 0) ? 0 : cur;
      exp_mreq   = (cur >= 0) && !acc;
      exp_fields = exp_mreq ? {f_wr[own], f_size[own], f_wstrb[own], f_addr[own], f_wdata[own]}
                            : 71'd0;
      exp_aok[0] = exp_mreq && own == 0 && mem_bus.addr_ok;
      exp_aok[1] = exp_mreq && own == 1 && mem_bus.addr_ok;
      retire     = (cur >= 0) && acc && mem_bus.data_ok;
      exp_dok[0] = retire && own == 0 && !drop && !inst_cancel;
      exp_dok[1] = retire && own == 1;
      exp_rd[0]  = exp_dok[0] ? mem_bus.rdata : 32'd0;
      exp_rd[1]  = exp_dok[1] ? mem_bus.rdata : 32'd0;

      if (exp_mreq && !pend[own]) begin
        n_err++; $display("FAIL rnd_protocol[%0d]: owner %0d dropped req before addr_ok", t, own);
      end
      n_vec++;
      if (mem_bus.req !== exp_mreq) begin
        n_err++; $display("FAIL rnd_m_req[%0d]: got %b want %b", t, mem_bus.req, exp_mreq);
      end
      n_vec++;
      if ({mem_bus.wr, mem_bus.size, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata} !==
          exp_fields) begin
        n_err++; $display("FAIL rnd_m_fields[%0d]: got %h want %h", t,
                          {mem_bus.wr, mem_bus.size, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata},
                          exp_fields);
      end
      n_vec++;
      if ({data_bus.addr_ok, inst_bus.addr_ok} !== exp_aok) begin
        n_err++; $display("FAIL rnd_addr_ok[%0d]: data/inst got %b%b want %b", t,
                          data_bus.addr_ok, inst_bus.addr_ok, exp_aok);
      end
      n_vec++;
      if ({data_bus.data_ok, inst_bus.data_ok} !== exp_dok) begin
        n_err++; $display("FAIL rnd_data_ok[%0d]: data/inst got %b%b want %b", t,
                          data_bus.data_ok, inst_bus.data_ok, exp_dok);
      end
      n_vec++;
      if (inst_bus.rdata !== exp_rd[0]) begin
        n_err++; $display("FAIL rnd_inst_rdata[%0d]: got %h want %h", t, inst_bus.rdata,
                          exp_rd[0]);
      end
      n_vec++;
      if (data_bus.rdata !== exp_rd[1]) begin
        n_err++; $display("FAIL rnd_data_rdata[%0d]: got %h want %h", t, data_bus.rdata,
                          exp_rd[1]);
      end

      if (cur == 0 && inst_cancel) drop = 1'b1;
      if (retire) begin
        cur = -1; acc = 1'b0; drop = 1'b0;
      end else if (cur < 0) begin
        if (pend[0] || pend[1]) begin
          cur      = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
          acc      = 1'b0;
          drop     = 1'b0;
          wait_cnt = $urandom_range(0, 2);
        end
      end else if (!acc && mem_bus.addr_ok) begin
        acc      = 1'b1;
        last     = cur;
        pend[cur] = 1'b0;
        wait_cnt = $urandom_range(0, 3);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_inst_read();
    test_tie();
    test_alternate();
    test_cancel();
    test_data_write();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
